alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 25 ++
 rtl/alu_opdecoder.sv | 34 +++
 rtl/alu_sequencer.sv | 112 +++++++++++
 tb/tb_alu_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: LEGv8 opcodes, ALU control codes, FSM states.
package alu_sequencer_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_ORR     = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_PASSB   = 4'b0111;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_opdecoder.sv
// Combinational LEGv8 opcode decode to a 4-bit ALU control plus an illegal flag.
module alu_opdecoder
    import alu_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic        illegal
);

    // Only the opcode field is decoded; the operand fields are ignored.
    logic unused_fields;
    assign unused_fields = ^instr[20:0];

    always_comb begin
        alu_control = ALU_ILLEGAL;
        illegal     = 1'b0;
        case (instr[31:21])
            OP_ADD, OP_LDUR, OP_STUR: alu_control = ALU_ADD;
            OP_SUB:                   alu_control = ALU_SUB;
            OP_AND:                   alu_control = ALU_AND;
            OP_ORR:                   alu_control = ALU_ORR;
            default: begin
                // CBZ only has an 8-bit opcode, so it is tried after the 11-bit set.
                if (instr[31:24] == OP_CBZ) begin
                    alu_control = ALU_PASSB;
                end else begin
                    alu_control = ALU_ILLEGAL;
                    illegal     = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-outstanding request sequencer around an external combinational ALU:
// IDLE accepts and decodes, EXEC drives the ALU and captures, RESP holds until consumed.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_instr,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_illegal,
    output logic [15:0]  op_count
);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q;
    logic [3:0]   ctrl_q;
    logic         illegal_q;
    logic [N-1:0] result_q;
    logic         zero_q;
    logic [15:0]  count_q;

    logic [3:0]   dec_control;
    logic         dec_illegal;
    logic         accept;

    alu_opdecoder u_dec (
        .instr       (req_instr),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = 4'b0000;
        case (state_q)
            IDLE: begin
                // Held low during reset so no accept lands on the reset edge.
                req_ready = !reset;
                if (req_valid && !reset) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_control = ctrl_q;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 4'b0000;
            illegal_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q       <= req_a;
                b_q       <= req_b;
                ctrl_q    <= dec_control;
                illegal_q <= dec_illegal;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
            if (state_q == RESP && rsp_ready) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = illegal_q;
    assign op_count    = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural external ALU.
module tb_alu_sequencer;

    localparam int unsigned N = 64;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_instr;
    logic [N-1:0] req_a, req_b;
    logic [N-1:0] alu_a, alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_illegal;
    logic [15:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr   (req_instr),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: unknown control codes yield all ones.
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = '1;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Present one request at a negedge and let the accept edge pass; ends in EXEC.
    task automatic issue(input logic [31:0] instr, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_instr = instr;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_instr = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        n_checks++; if (rsp_result !== '0 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_fields got=%h/%0b/%0b exp=0/0/0", rsp_result, rsp_zero, rsp_illegal); end
        n_checks++; if (alu_control !== 4'b0000 || alu_a !== '0) begin
            n_fail++; $display("FAIL reset_alu_idle got=%b/%h exp=0000/0", alu_control, alu_a); end
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_add;
        rsp_ready = 1'b1;
        issue({11'b10001011000, 21'h0}, 64'd5, 64'd7);
        n_checks++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL add_ctrl got=%b exp=0010", alu_control); end
        n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7) begin n_fail++; $display("FAIL add_operands got=%0d/%0d exp=5/7", alu_a, alu_b); end
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL add_exec_handshake got=%0b/%0b exp=0/0", rsp_valid, req_ready); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got=%0b exp=1", rsp_valid); end
        n_checks++; if (rsp_result !== 64'd12 || rsp_zero !== 1'b0 || rsp_illegal !== 1'b0) begin
            n_fail++; $display("FAIL add_result got=%0d/%0b/%0b exp=12/0/0", rsp_result, rsp_zero, rsp_illegal); end
        n_checks++; if (alu_control !== 4'b0000 || alu_b !== '0) begin
            n_fail++; $display("FAIL add_resp_alu_idle got=%b/%h exp=0000/0", alu_control, alu_b); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_count got=%0d/%0b exp=1/0", op_count, rsp_valid); end
    endtask

    task automatic test_sub_zero;
        rsp_ready = 1'b1;
        issue({11'b11001011000, 21'h1abc}, 64'h1234, 64'h1234);
        n_checks++; if (alu_control !== 4'b0110) begin n_fail++; $display("FAIL sub_ctrl got=%b exp=0110", alu_control); end
        @(negedge clk);
        n_checks++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin
            n_fail++; $display("FAIL sub_zero got=%h/%0b exp=0/1", rsp_result, rsp_zero); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd2) begin n_fail++; $display("FAIL sub_count got=%0d exp=2", op_count); end
    endtask

    task automatic test_decode;
        logic [10:0]  ops  [4] = '{11'b10001010000, 11'b10101010000, 11'b11111000010, 11'b11111000000};
        logic [3:0]   ctl  [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010};
        logic [N-1:0] res  [4] = '{64'h00F0, 64'hFFFF, 64'h0F0F + 64'h0FF0, 64'h0F0F + 64'h0FF0};
        logic [N-1:0] as_  [4] = '{64'h0FF0, 64'h0FF0, 64'h0F0F, 64'h0F0F};
        logic [N-1:0] bs_  [4] = '{64'hF0F0, 64'hF00F, 64'h0FF0, 64'h0FF0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue({ops[i], 21'h0}, as_[i], bs_[i]);
            n_checks++; if (alu_control !== ctl[i]) begin n_fail++; $display("FAIL decode_ctrl[%0d] got=%b exp=%b", i, alu_control, ctl[i]); end
            @(negedge clk);
            n_checks++; if (rsp_result !== res[i]) begin n_fail++; $display("FAIL decode_result[%0d] got=%h exp=%h", i, rsp_result, res[i]); end
            @(negedge clk);
        end
        n_checks++; if (op_count !== 16'd6) begin n_fail++; $display("FAIL decode_count got=%0d exp=6", op_count); end
    endtask

    task automatic test_backpressure;
        logic [15:0] cnt0;
        cnt0 = op_count;
        rsp_ready = 1'b0;
        issue({8'b10110100, 24'h00_0042}, 64'd9, 64'd0);
        n_checks++; if (alu_control !== 4'b0111) begin n_fail++; $display("FAIL cbz_ctrl got=%b exp=0111", alu_control); end
        // A competing request is held during the stall and must not be taken.
        req_valid = 1'b1;
        req_instr = {11'b10001011000, 21'h0};
        req_a     = 64'd1;
        req_b     = 64'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_handshake[%0d] got=%0b/%0b exp=1/0", c, rsp_valid, req_ready); end
            n_checks++; if (rsp_result !== 64'd0 || rsp_zero !== 1'b1 || rsp_illegal !== 1'b0) begin
                n_fail++; $display("FAIL bp_stable[%0d] got=%h/%0b/%0b exp=0/1/0", c, rsp_result, rsp_zero, rsp_illegal); end
            n_checks++; if (op_count !== cnt0) begin n_fail++; $display("FAIL bp_count[%0d] got=%0d exp=%0d", c, op_count, cnt0); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (op_count !== cnt0 + 16'd1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got=%0d/%0b exp=%0d/0", op_count, rsp_valid, cnt0 + 16'd1); end
    endtask

    task automatic test_illegal;
        rsp_ready = 1'b1;
        issue(32'h0000_0000, 64'd3, 64'd4);
        n_checks++; if (alu_control !== 4'b1111) begin n_fail++; $display("FAIL illegal_ctrl got=%b exp=1111", alu_control); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== {N{1'b1}} || rsp_zero !== 1'b0 || rsp_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_rsp got=%0b/%h/%0b/%0b exp=1/ffffffffffffffff/0/1",
                               rsp_valid, rsp_result, rsp_zero, rsp_illegal); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        rsp_ready = 1'b0;
        issue({11'b10001011000, 21'h0}, 64'd100, 64'd200);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_in_resp got=%0b exp=1", rsp_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low got=%0b exp=0", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || rsp_result !== '0) begin
            n_fail++; $display("FAIL midrst_cleared got=%0b/%0d/%h exp=0/0/0", rsp_valid, op_count, rsp_result); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%0b exp=1", req_ready); end
        rsp_ready = 1'b1;
        issue({11'b10101010000, 21'h0}, 64'hF0, 64'h0F);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'hFF) begin
            n_fail++; $display("FAIL midrst_next got=%0b/%h exp=1/ff", rsp_valid, rsp_result); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        #1;
        n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffff", op_count); end
        rsp_ready = 1'b1;
        issue({11'b10001011000, 21'h0}, 64'd1, 64'd1);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count got=%h exp=0000", op_count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_decode();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
